// File: rtl/keypad_entry_pkg.sv
// Shared definitions for the keypad entry front end.
//   - key codes delivered by the keypad scanner (0-9 are digits)
//   - entry mode values sampled on the first key of an entry
//   - FSM state encoding, also exported on the debug port
package keypad_entry_pkg;

  localparam logic [3:0] KEY_CLEAR  = 4'd10;
  localparam logic [3:0] KEY_ENTER  = 4'd11;
  localparam logic [3:0] KEY_CANCEL = 4'd12;

  localparam logic MODE_PIN = 1'b0;
  localparam logic MODE_AMT = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PIN_ENTRY = 2'd1,
    AMT_ENTRY = 2'd2
  } state_t;

  function automatic logic is_digit_code(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/keypad_entry_timer.sv
// entry_timer: inactivity timer for an open keypad entry.
//   clock   : system clock, rising edge
//   reset   : asynchronous, active-low
//   run     : count while high (an entry is open); held at 0 otherwise
//   reload  : restart the idle count from 0 (a key arrived)
//   expired : one-cycle pulse when TIMEOUT_CYCLES idle cycles have elapsed
module entry_timer #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TO_W           = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic reload,
  output logic expired
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] cnt;

  // A key in the expiry cycle wins, so reload masks the pulse.
  assign expired = run && !reload && (cnt == LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!run || reload || expired) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// keypad_entry: assembles PIN digits and decimal amounts from keypad events
// and presents complete entries to the ATM controller.
//   clock, reset     : rising-edge clock, asynchronous active-low reset
//   keyValid/keyCode : one-cycle key event; 0-9 digit, 10 CLEAR, 11 ENTER,
//                      12 CANCEL, 13-15 ignored (still count as activity)
//   mode             : 0 PIN, 1 amount; looked at only on the first key
//   digit/stdDigit   : last PIN digit and its one-cycle strobe
//   pin/pinReady     : assembled PIN (first digit in MSB nibble) and strobe
//   amount/stbAmount : binary amount and strobe; amount holds between strobes
//   busy             : an entry is open
//   entryError       : one-cycle pulse on malformed entry or timeout
//   dbg_state        : current FSM state
//
// Handshake: keyValid is a pure valid with no ready. The block accepts every
// event in the cycle it is presented, at most one event per cycle, and each
// accepted event shows its effect on the registered outputs one cycle later.
module keypad_entry
  import keypad_entry_pkg::*;
#(
  parameter int PIN_DIGITS     = 4,
  parameter int AMOUNT_DIGITS  = 9,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TO_W           = 10
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    keyValid,
  input  logic [3:0]              keyCode,
  input  logic                    mode,
  output logic [3:0]              digit,
  output logic                    stdDigit,
  output logic [4*PIN_DIGITS-1:0] pin,
  output logic                    pinReady,
  output logic [31:0]             amount,
  output logic                    stbAmount,
  output logic                    busy,
  output logic                    entryError,
  output state_t                  dbg_state
);

  localparam int PW    = 4 * PIN_DIGITS;
  localparam int MAXD  = (AMOUNT_DIGITS > PIN_DIGITS) ? AMOUNT_DIGITS : PIN_DIGITS;
  localparam int CNT_W = $clog2(MAXD + 1);

  state_t           state_q, state_n;
  logic [CNT_W-1:0] count_q, count_n;
  logic [31:0]      acc_q, acc_n;

  logic [3:0]    digit_n;
  logic          std_n, prdy_n, stb_n, err_n;
  logic [PW-1:0] pin_n, pin_base;
  logic [31:0]   amount_n;
  logic          key_digit, expired;

  assign key_digit = keyValid && is_digit_code(keyCode);
  assign dbg_state = state_q;
  // A fresh PIN always starts from zero so nothing from an older PIN leaks in.
  assign pin_base  = (state_q == IDLE) ? '0 : pin;

  entry_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_W           (TO_W)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .run     (state_q != IDLE),
    .reload  (keyValid),
    .expired (expired)
  );

  always_comb begin
    state_n  = state_q;
    count_n  = count_q;
    acc_n    = acc_q;
    digit_n  = digit;
    pin_n    = pin;
    amount_n = amount;
    std_n    = 1'b0;
    prdy_n   = 1'b0;
    stb_n    = 1'b0;
    err_n    = 1'b0;

    if (expired) begin
      err_n   = 1'b1;
      state_n = IDLE;
      count_n = '0;
      acc_n   = '0;
      if (state_q == PIN_ENTRY) pin_n = '0;
    end else begin
      case (state_q)
        IDLE, PIN_ENTRY: begin
          if (key_digit && (state_q == PIN_ENTRY || mode == MODE_PIN)) begin
            pin_n   = {pin_base[PW-5:0], keyCode};
            digit_n = keyCode;
            std_n   = 1'b1;
            if (count_q == CNT_W'(PIN_DIGITS - 1)) begin
              prdy_n  = 1'b1;
              state_n = IDLE;
              count_n = '0;
            end else begin
              state_n = PIN_ENTRY;
              count_n = count_q + 1'b1;
            end
          end else if (key_digit) begin
            // First key of an amount entry; the accumulator is already 0.
            acc_n   = 32'(keyCode);
            count_n = CNT_W'(1);
            state_n = AMT_ENTRY;
          end else if (keyValid && state_q == PIN_ENTRY) begin
            case (keyCode)
              KEY_CLEAR: begin
                pin_n   = '0;
                count_n = '0;
              end
              KEY_ENTER: begin
                err_n   = 1'b1;
                pin_n   = '0;
                count_n = '0;
                state_n = IDLE;
              end
              KEY_CANCEL: begin
                pin_n   = '0;
                count_n = '0;
                state_n = IDLE;
              end
              default: ;
            endcase
          end
        end

        AMT_ENTRY: begin
          if (key_digit) begin
            if (count_q == CNT_W'(AMOUNT_DIGITS)) begin
              err_n = 1'b1;
            end else begin
              acc_n   = acc_q * 32'd10 + 32'(keyCode);
              count_n = count_q + 1'b1;
            end
          end else if (keyValid) begin
            case (keyCode)
              KEY_CLEAR: begin
                acc_n   = '0;
                count_n = '0;
              end
              KEY_ENTER: begin
                // count is 0 here only after a CLEAR.
                if (count_q != '0) begin
                  amount_n = acc_q;
                  stb_n    = 1'b1;
                end else begin
                  err_n = 1'b1;
                end
                acc_n   = '0;
                count_n = '0;
                state_n = IDLE;
              end
              KEY_CANCEL: begin
                acc_n   = '0;
                count_n = '0;
                state_n = IDLE;
              end
              default: ;
            endcase
          end
        end

        default: begin
          state_n = IDLE;
          count_n = '0;
          acc_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      acc_q      <= '0;
      digit      <= '0;
      stdDigit   <= 1'b0;
      pin        <= '0;
      pinReady   <= 1'b0;
      amount     <= '0;
      stbAmount  <= 1'b0;
      busy       <= 1'b0;
      entryError <= 1'b0;
    end else begin
      state_q    <= state_n;
      count_q    <= count_n;
      acc_q      <= acc_n;
      digit      <= digit_n;
      stdDigit   <= std_n;
      pin        <= pin_n;
      pinReady   <= prdy_n;
      amount     <= amount_n;
      stbAmount  <= stb_n;
      busy       <= (state_n != IDLE);
      entryError <= err_n;
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
module tb_keypad_entry;
  import keypad_entry_pkg::*;

  localparam int T = 1000;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        keyValid = 1'b0;
  logic [3:0]  keyCode = 4'd0;
  logic        mode = 1'b0;
  logic [3:0]  digit;
  logic        stdDigit;
  logic [15:0] pin;
  logic        pinReady;
  logic [31:0] amount;
  logic        stbAmount;
  logic        busy;
  logic        entryError;
  state_t      dbg_state;

  always #5 clock = ~clock;

  keypad_entry #(
    .PIN_DIGITS     (4),
    .AMOUNT_DIGITS  (9),
    .TIMEOUT_CYCLES (T),
    .TO_W           (10)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .keyValid   (keyValid),
    .keyCode    (keyCode),
    .mode       (mode),
    .digit      (digit),
    .stdDigit   (stdDigit),
    .pin        (pin),
    .pinReady   (pinReady),
    .amount     (amount),
    .stbAmount  (stbAmount),
    .busy       (busy),
    .entryError (entryError),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        kv;
    logic [3:0]  kc;
    logic        md;
    logic [3:0]  dig;
    logic        std;
    logic [15:0] pn;
    logic        prdy;
    logic [31:0] amt;
    logic        stb;
    logic        bsy;
    logic        err;
  } vec_t;

  vec_t vecs[$];
  logic [56:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [56:0] outs();
    return {digit, stdDigit, pin, pinReady, amount, stbAmount, busy, entryError};
  endfunction

  task automatic add(input logic kv, input logic [3:0] kc, input logic md,
                     input logic [3:0] dig, input logic std, input logic [15:0] pn,
                     input logic prdy, input logic [31:0] amt, input logic stb,
                     input logic bsy, input logic err);
    vec_t v;
    v.kv = kv; v.kc = kc; v.md = md; v.dig = dig; v.std = std; v.pn = pn;
    v.prdy = prdy; v.amt = amt; v.stb = stb; v.bsy = bsy; v.err = err;
    vecs.push_back(v);
  endtask

  // ---------------- driver ----------------
  // Inputs change at the falling edge; outputs are read at the next falling
  // edge, i.e. one rising edge after the key was sampled.
  task automatic step(input logic kv, input logic [3:0] kc, input logic md);
    keyValid = kv;
    keyCode  = kc;
    mode     = md;
    @(negedge clock);
    keyValid = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 1'b0);
  endtask

  int prdy_cnt;
  int err_cnt;

  initial begin
    // ---- reset state ----
    #1;
    check("reset_outputs", outs(), 57'd0);
    check("reset_state", dbg_state, IDLE);
    @(negedge clock);
    reset = 1'b1;
    idle();

    // ---- table: kv kc md | digit std pin prdy amount stb busy err ----
    // full PIN 4,0,9,7
    add(1, 4'd4,  0,  4'd4, 1, 16'h0004, 0, 32'd0, 0, 1, 0);
    add(1, 4'd0,  0,  4'd0, 1, 16'h0040, 0, 32'd0, 0, 1, 0);
    add(1, 4'd9,  0,  4'd9, 1, 16'h0409, 0, 32'd0, 0, 1, 0);
    add(1, 4'd7,  0,  4'd7, 1, 16'h4097, 1, 32'd0, 0, 0, 0);
    add(0, 4'd0,  0,  4'd7, 0, 16'h4097, 0, 32'd0, 0, 0, 0);
    // ENTER, CLEAR and 14 in IDLE change nothing
    add(1, 4'd11, 0,  4'd7, 0, 16'h4097, 0, 32'd0, 0, 0, 0);
    add(1, 4'd10, 0,  4'd7, 0, 16'h4097, 0, 32'd0, 0, 0, 0);
    add(1, 4'd14, 1,  4'd7, 0, 16'h4097, 0, 32'd0, 0, 0, 0);
    // nine 9s, a rejected tenth, then ENTER
    for (int k = 0; k < 9; k++)
      add(1, 4'd9, 1, 4'd7, 0, 16'h4097, 0, 32'd0, 0, 1, 0);
    add(1, 4'd9,  1,  4'd7, 0, 16'h4097, 0, 32'd0,         0, 1, 1);
    add(1, 4'd11, 1,  4'd7, 0, 16'h4097, 0, 32'd999999999, 1, 0, 0);
    add(0, 4'd0,  0,  4'd7, 0, 16'h4097, 0, 32'd999999999, 0, 0, 0);
    // 5, CLEAR, 1, 2, ENTER; mode flips mid-entry and must be ignored
    add(1, 4'd5,  1,  4'd7, 0, 16'h4097, 0, 32'd999999999, 0, 1, 0);
    add(1, 4'd10, 1,  4'd7, 0, 16'h4097, 0, 32'd999999999, 0, 1, 0);
    add(1, 4'd1,  0,  4'd7, 0, 16'h4097, 0, 32'd999999999, 0, 1, 0);
    add(1, 4'd2,  0,  4'd7, 0, 16'h4097, 0, 32'd999999999, 0, 1, 0);
    add(1, 4'd11, 0,  4'd7, 0, 16'h4097, 0, 32'd12,        1, 0, 0);
    // 3, CLEAR, ENTER -> error, amount kept
    add(1, 4'd3,  1,  4'd7, 0, 16'h4097, 0, 32'd12, 0, 1, 0);
    add(1, 4'd10, 1,  4'd7, 0, 16'h4097, 0, 32'd12, 0, 1, 0);
    add(1, 4'd11, 1,  4'd7, 0, 16'h4097, 0, 32'd12, 0, 0, 1);
    // PIN 1, 2, ENTER -> error, pin cleared, no pinReady
    add(1, 4'd1,  0,  4'd1, 1, 16'h0001, 0, 32'd12, 0, 1, 0);
    add(1, 4'd2,  0,  4'd2, 1, 16'h0012, 0, 32'd12, 0, 1, 0);
    add(1, 4'd11, 0,  4'd2, 0, 16'h0000, 0, 32'd12, 0, 0, 1);
    // PIN 7, CANCEL -> quiet return to IDLE
    add(1, 4'd7,  0,  4'd7, 1, 16'h0007, 0, 32'd12, 0, 1, 0);
    add(1, 4'd12, 0,  4'd7, 0, 16'h0000, 0, 32'd12, 0, 0, 0);
    add(0, 4'd0,  0,  4'd7, 0, 16'h0000, 0, 32'd12, 0, 0, 0);

    foreach (vecs[i])
      exp_q.push_back({vecs[i].dig, vecs[i].std, vecs[i].pn, vecs[i].prdy,
                       vecs[i].amt, vecs[i].stb, vecs[i].bsy, vecs[i].err});
    foreach (vecs[i]) begin
      logic [56:0] e;
      step(vecs[i].kv, vecs[i].kc, vecs[i].md);
      e = exp_q.pop_front();
      check($sformatf("vec%0d", i), outs(), e);
    end

    // ---- reset mid-PIN, then a clean PIN 1,2,3,4 ----
    step(1, 4'd5, 0);
    step(1, 4'd6, 0);
    #2 reset = 1'b0;
    #1;
    check("midreset_outputs", outs(), 57'd0);
    check("midreset_state", dbg_state, IDLE);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    prdy_cnt = 0;
    step(1, 4'd1, 0);
    prdy_cnt += int'(pinReady);
    check("postreset_first", {digit, stdDigit, pin}, {4'd1, 1'b1, 16'h0001});
    step(1, 4'd2, 0); prdy_cnt += int'(pinReady);
    step(1, 4'd3, 0); prdy_cnt += int'(pinReady);
    step(1, 4'd4, 0); prdy_cnt += int'(pinReady);
    check("postreset_pin", {pin, pinReady, busy}, {16'h1234, 1'b1, 1'b0});
    idle(); prdy_cnt += int'(pinReady);
    idle(); prdy_cnt += int'(pinReady);
    check("postreset_prdy_once", prdy_cnt, 1);

    // ---- timeout: PIN 7 then silence ----
    step(1, 4'd7, 0);
    err_cnt = 0;
    repeat (T - 1) begin
      idle();
      err_cnt += int'(entryError);
    end
    check("timeout_early", err_cnt, 0);
    idle();
    check("timeout_fire", {entryError, busy, pin}, {1'b1, 1'b0, 16'h0000});
    idle();
    check("timeout_once", {entryError, dbg_state}, {1'b0, IDLE});

    // ---- key landing in the expiry cycle wins ----
    step(1, 4'd7, 0);
    err_cnt = 0;
    repeat (T - 1) begin
      idle();
      err_cnt += int'(entryError);
    end
    step(1, 4'd8, 0);
    err_cnt += int'(entryError);
    check("expiry_key_noerr", err_cnt, 0);
    check("expiry_key_taken", {stdDigit, digit, pin, busy}, {1'b1, 4'd8, 16'h0078, 1'b1});
    step(1, KEY_CANCEL, 0);
    check("expiry_cancel", {busy, entryError, pin}, {1'b0, 1'b0, 16'h0000});

    // ---- code 14 only restarts the timeout ----
    step(1, 4'd7, 0);
    repeat (T - 2) idle();
    step(1, 4'd14, 0);
    check("code14_noeffect", {stdDigit, digit, pin, busy, entryError},
          {1'b0, 4'd7, 16'h0007, 1'b1, 1'b0});
    err_cnt = 0;
    repeat (T - 1) begin
      idle();
      err_cnt += int'(entryError);
    end
    check("code14_extended", err_cnt, 0);
    idle();
    check("code14_timeout", {entryError, busy}, {1'b1, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
